estufa_multizona: RTL and testbench

//  Parametrised greenhouse climate controller for NZONES independent zones.
//  Per zone: heater/cooler FSM with hysteresis, minimum on-time and, optionally, a watchdog fault.

---
 rtl/estufa_pkg.sv | 25 ++
 rtl/estufa_zona.sv | 102 ++++++++++
 rtl/estufa_multizona.sv | 46 ++++
 tb/tb_estufa_multizona.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/estufa_pkg.sv
// Shared types, default thresholds and helpers for the multi-zone greenhouse controller.
// Build option: ESTUFA_WATCHDOG_EN enables the per-zone watchdog and FAULT state.
package estufa_pkg;

    typedef enum logic [1:0] {IDLE, HEAT, COOL, FAULT} zone_state_t;

    localparam int DEF_NZONES = 2;
    localparam int DEF_TW     = 8;
    localparam int DEF_T_LOW  = 15;
    localparam int DEF_T_MID  = 18;
    localparam int DEF_T_HIGH = 20;
    localparam int DEF_MIN_ON = 4;
    localparam int DEF_MAX_ON = 16;

    // Widest packed temperature bus the extraction helper handles.
    localparam int PACK_MAX = 256;

    function automatic logic [31:0] zone_temp(input logic [PACK_MAX-1:0] packed_temp,
                                              input int zone, input int tw);
        logic [PACK_MAX-1:0] shifted;
        shifted = packed_temp >> (zone * tw);
        return shifted[31:0] & ((32'd1 << tw) - 32'd1);
    endfunction

endpackage

// File: rtl/estufa_zona.sv
// One greenhouse zone: heat/cool FSM with hysteresis, minimum on-time and dwell counter.
// Build option: ESTUFA_WATCHDOG_EN adds the MAX_ON watchdog and latched FAULT state.
module estufa_zona
    import estufa_pkg::*;
#(
    parameter int TW     = DEF_TW,
    parameter int T_LOW  = DEF_T_LOW,
    parameter int T_MID  = DEF_T_MID,
    parameter int T_HIGH = DEF_T_HIGH,
    parameter int MIN_ON = DEF_MIN_ON,
    parameter int MAX_ON = DEF_MAX_ON
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          enable,
    input  logic [TW-1:0] temp,
    input  logic          alarm_ack,
    output logic          heater,
    output logic          cooler,
    output logic          fault
);

`ifdef ESTUFA_WATCHDOG_EN
    localparam int CNT_MAX = MAX_ON;
`else
    localparam int CNT_MAX = MIN_ON;
`endif
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_ON);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [TW-1:0] LOW     = TW'(T_LOW);
    localparam logic [TW-1:0] MID     = TW'(T_MID);
    localparam logic [TW-1:0] HIGH    = TW'(T_HIGH);

    zone_state_t   state;
    logic [CW-1:0] cnt;
    logic          want_exit;

    // Leaving HEAT/COOL is requested by the hysteresis point or by enable dropping.
    always_comb begin
        want_exit = !enable;
        if (state == HEAT && temp >= MID) want_exit = 1'b1;
        if (state == COOL && temp <= MID) want_exit = 1'b1;
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && temp < LOW) begin
                        state <= HEAT;
                        cnt   <= CNT_ONE;
                    end else if (enable && temp > HIGH) begin
                        state <= COOL;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                HEAT, COOL: begin
                    if (want_exit && cnt >= CNT_MIN) begin
                        state <= IDLE;
                        cnt   <= '0;
`ifdef ESTUFA_WATCHDOG_EN
                    end else if (cnt == CNT_SAT) begin
                        // An ack arriving in this same cycle cannot pre-empt the new fault.
                        state <= FAULT;
                        cnt   <= '0;
`endif
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`ifdef ESTUFA_WATCHDOG_EN
                FAULT: begin
                    if (alarm_ack) state <= IDLE;
                    cnt <= '0;
                end
`endif
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign heater = (state == HEAT);
    assign cooler = (state == COOL);
`ifdef ESTUFA_WATCHDOG_EN
    assign fault  = (state == FAULT);
`else
    logic unused_ack;
    assign unused_ack = alarm_ack;
    assign fault      = 1'b0;
`endif

endmodule

// File: rtl/estufa_multizona.sv
// Multi-zone greenhouse climate controller: NZONES independent zones plus a shared alarm.
// Build option: ESTUFA_WATCHDOG_EN enables per-zone watchdog faults and the alarm.
module estufa_multizona
    import estufa_pkg::*;
#(
    parameter int NZONES = DEF_NZONES,
    parameter int TW     = DEF_TW,
    parameter int T_LOW  = DEF_T_LOW,
    parameter int T_MID  = DEF_T_MID,
    parameter int T_HIGH = DEF_T_HIGH,
    parameter int MIN_ON = DEF_MIN_ON,
    parameter int MAX_ON = DEF_MAX_ON
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NZONES*TW-1:0] temp,
    input  logic                 alarm_ack,
    output logic [NZONES-1:0]    heater,
    output logic [NZONES-1:0]    cooler,
    output logic [NZONES-1:0]    fault,
    output logic                 alarm
);

    for (genvar z = 0; z < NZONES; z++) begin : g_zone
        logic [TW-1:0] zone_t;
        assign zone_t = TW'(zone_temp(PACK_MAX'(temp), z, TW));

        estufa_zona #(
            .TW(TW), .T_LOW(T_LOW), .T_MID(T_MID), .T_HIGH(T_HIGH),
            .MIN_ON(MIN_ON), .MAX_ON(MAX_ON)
        ) u_zona (
            .clk_2     (clk_2),
            .reset     (reset),
            .enable    (enable),
            .temp      (zone_t),
            .alarm_ack (alarm_ack),
            .heater    (heater[z]),
            .cooler    (cooler[z]),
            .fault     (fault[z])
        );
    end

    assign alarm = |fault;

endmodule

// File: tb/tb_estufa_multizona.sv
// Scoreboard bench for estufa_multizona: randomized and directed zone temperatures
// checked against a rule-level reference model; honours ESTUFA_WATCHDOG_EN.
module tb_estufa_multizona;

    localparam int NZ     = 2;
    localparam int TW     = 8;
    localparam int T_LOW  = 15;
    localparam int T_MID  = 18;
    localparam int T_HIGH = 20;
    localparam int MIN_ON = 4;
    localparam int MAX_ON = 16;
`ifdef ESTUFA_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic              clk_2 = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [NZ*TW-1:0]  temp = '0;
    logic              alarm_ack = 1'b0;
    logic [NZ-1:0]     heater, cooler, fault;
    logic              alarm;

    int checks = 0;
    int errors = 0;

    // Expected {alarm, fault, cooler, heater} after the next rising edge.
    logic [3*NZ:0] exp_q[$];

    // Reference model: mode 0 idle, 1 heating, 2 cooling, 3 faulted; age = cycles in mode.
    int mode[NZ];
    int age[NZ];
    int cur_t[NZ];

    estufa_multizona #(
        .NZONES(NZ), .TW(TW), .T_LOW(T_LOW), .T_MID(T_MID), .T_HIGH(T_HIGH),
        .MIN_ON(MIN_ON), .MAX_ON(MAX_ON)
    ) dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .enable    (enable),
        .temp      (temp),
        .alarm_ack (alarm_ack),
        .heater    (heater),
        .cooler    (cooler),
        .fault     (fault),
        .alarm     (alarm)
    );

    always #5 clk_2 = ~clk_2;

    task automatic model_reset();
        for (int z = 0; z < NZ; z++) begin
            mode[z] = 0;
            age[z]  = 0;
        end
    endtask

    task automatic model_step(input logic en, input logic ack);
        for (int z = 0; z < NZ; z++) begin
            int  t;
            bit  satisfied;
            t = cur_t[z];
            case (mode[z])
                0: begin
                    if (en && t < T_LOW) begin mode[z] = 1; age[z] = 1; end
                    else if (en && t > T_HIGH) begin mode[z] = 2; age[z] = 1; end
                end
                1, 2: begin
                    satisfied = (mode[z] == 1) ? (t >= T_MID) : (t <= T_MID);
                    if ((satisfied || !en) && age[z] >= MIN_ON) begin
                        mode[z] = 0; age[z] = 0;
                    end else if (WD && age[z] >= MAX_ON) begin
                        mode[z] = 3; age[z] = 0;
                    end else begin
                        age[z]++;
                    end
                end
                default: if (ack) mode[z] = 0;
            endcase
        end
    endtask

    function automatic logic [3*NZ:0] model_outputs();
        logic [3*NZ:0] e;
        e = '0;
        for (int z = 0; z < NZ; z++) begin
            e[z]        = (mode[z] == 1);
            e[NZ + z]   = (mode[z] == 2);
            e[2*NZ + z] = (mode[z] == 3);
            if (mode[z] == 3) e[3*NZ] = 1'b1;
        end
        return e;
    endfunction

    task automatic check_output(input string name, input logic [3*NZ:0] act,
                                input logic [3*NZ:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Drive one input pattern for n cycles, queueing the model's expected outputs.
    task automatic apply_stimulus(input logic en, input logic ack, input int t0,
                                  input int t1, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_2);
            enable    = en;
            alarm_ack = (i == 0) ? ack : 1'b0;
            temp      = {TW'(t1), TW'(t0)};
            cur_t[0]  = t0;
            cur_t[1]  = t1;
            model_step(enable, alarm_ack);
            exp_q.push_back(model_outputs());
        end
    endtask

    initial begin : monitor
        logic [3*NZ:0] req;
        forever begin
            @(posedge clk_2);
            #1;
            if (exp_q.size() > 0) begin
                req = exp_q.pop_front();
                check_output("outputs", {alarm, fault, cooler, heater}, req);
            end
        end
    end

    initial begin : timeout
        #200000;
        $display("[TB] FAIL timeout t=%0t actual=running required=finished", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        model_reset();
        temp = {TW'(5), TW'(5)};
        repeat (2) @(posedge clk_2);
        @(negedge clk_2);
        check_output("reset_state", {alarm, fault, cooler, heater}, '0);
        reset = 1'b0;

        // Threshold equality, then heating entry and hysteresis.
        apply_stimulus(1, 0, 15, 19, 3);
        apply_stimulus(1, 0, 14, 19, 1);
        apply_stimulus(1, 0, 18, 19, 6);
        apply_stimulus(1, 0, 14, 19, 1);
        apply_stimulus(1, 0, 17, 19, 5);
        apply_stimulus(1, 0, 18, 19, 5);

        // Cooling, then a jump below T_LOW that must pass through idle.
        apply_stimulus(1, 0, 19, 21, 3);
        apply_stimulus(1, 0, 19, 10, 8);
        apply_stimulus(1, 0, 19, 19, 6);

        // Watchdog on zone0, then acknowledge and reheat.
        apply_stimulus(1, 0, 10, 19, 20);
        apply_stimulus(1, 1, 10, 19, 1);
        apply_stimulus(1, 0, 10, 19, 3);
        apply_stimulus(1, 0, 19, 19, 6);
        apply_stimulus(1, 1, 19, 19, 2);

        // Ack colliding with zone1 reaching the watchdog limit.
        for (int i = 0; i < 30; i++)
            apply_stimulus(1, (mode[1] == 2 && age[1] == MAX_ON), 19, 25, 1);
        apply_stimulus(1, 0, 19, 19, 3);
        apply_stimulus(1, 1, 19, 19, 2);

        // Enable dropped early in heating; minimum on-time still honoured.
        apply_stimulus(1, 0, 10, 19, 2);
        apply_stimulus(0, 0, 10, 19, 6);

        // Randomized segments around the thresholds.
        for (int s = 0; s < 60; s++) begin
            int t0, t1;
            logic en;
            t0 = $urandom_range(8, 25);
            t1 = $urandom_range(8, 25);
            en = ($urandom_range(0, 7) != 0);
            apply_stimulus(en, ($urandom_range(0, 5) == 0), t0, t1, 1);
            apply_stimulus(en, 0, t0, t1, $urandom_range(1, 20));
        end

        // Asynchronous reset between clock edges while zone0 heats.
        apply_stimulus(1, 1, 19, 19, 6);
        apply_stimulus(1, 0, 10, 19, 3);
        @(negedge clk_2);
        #2;
        enable = 1'b0;
        reset  = 1'b1;
        #1;
        check_output("async_reset", {alarm, fault, cooler, heater}, '0);
        model_reset();
        @(negedge clk_2);
        reset = 1'b0;
        apply_stimulus(1, 0, 10, 19, 3);
        apply_stimulus(1, 0, 19, 19, 6);

        @(posedge clk_2);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
